// File: rtl/tile_buffer_db_if.sv
// Pixel-port bundle for tile_buffer_db: write, read, clear and swap traffic.
// The master side is the rasteriser/scanout agent; the slave side is the buffer.
interface tile_buffer_db_if #(
    parameter int TW_LOG2 = 3,
    parameter int TH_LOG2 = 3,
    parameter int CH_N    = 3,
    parameter int CH_W    = 8
);
    localparam int PIX_W = CH_N * CH_W;

    logic               active;
    logic               wr_en;
    logic [TW_LOG2-1:0] wr_x;
    logic [TH_LOG2-1:0] wr_y;
    logic [PIX_W-1:0]   wr_data;
    logic [CH_N-1:0]    wr_mask;
    logic               rd_en;
    logic [TW_LOG2-1:0] rd_x;
    logic [TH_LOG2-1:0] rd_y;
    logic [PIX_W-1:0]   rd_data;
    logic               rd_valid;
    logic               clear_req;
    logic [PIX_W-1:0]   clear_color;
    logic               swap_req;
    logic               swap_done;
    logic               front_bank;
    logic               busy;

    // Requests are single-cycle strobes qualified by active; there is no
    // backpressure. rd_valid/swap_done are one-cycle pulses, busy is a level.
    modport master (
        output active, wr_en, wr_x, wr_y, wr_data, wr_mask,
        output rd_en, rd_x, rd_y, clear_req, clear_color, swap_req,
        input  rd_data, rd_valid, swap_done, front_bank, busy
    );

    modport slave (
        input  active, wr_en, wr_x, wr_y, wr_data, wr_mask,
        input  rd_en, rd_x, rd_y, clear_req, clear_color, swap_req,
        output rd_data, rd_valid, swap_done, front_bank, busy
    );
endinterface

// File: rtl/tile_buffer_db.sv
// Double-buffered tile store: rasteriser writes/clears the back bank while
// scanout reads the front bank; a swap exchanges them, deferred past a clear.
module tile_buffer_db #(
    parameter int TW_LOG2 = 3,
    parameter int TH_LOG2 = 3,
    parameter int CH_N    = 3,
    parameter int CH_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    tile_buffer_db_if.slave  bus,
    output logic             state_o
);
    localparam int PIX_W = CH_N * CH_W;
    localparam int AW    = TW_LOG2 + TH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [PIX_W-1:0] color_q;
    logic             swap_pend_q;
    logic             front_q;
    logic             swap_done_q;
    logic             busy_q;
    logic [PIX_W-1:0] rd_data_q;
    logic             rd_valid_q;

    // Both banks live in one array; the bank index is the address MSB.
    logic [PIX_W-1:0] mem_q [2*DEPTH];

    logic             clear_go;
    logic             swap_go;
    logic             wr_go;
    logic             rd_go;
    logic             mem_we;
    logic [AW:0]      mem_wa;
    logic [PIX_W-1:0] mem_wd;
    logic [CH_N-1:0]  mem_wm;
    logic [AW:0]      rd_addr;

    assign clear_go = bus.clear_req & bus.active;
    assign swap_go  = bus.swap_req  & bus.active;
    assign wr_go    = bus.wr_en     & bus.active & (state_q == S_IDLE);
    assign rd_go    = bus.rd_en     & bus.active;
    assign cnt_d    = cnt_q + CW'(1);
    assign rd_addr  = {front_q, bus.rd_y, bus.rd_x};

    // The sweep owns the back-bank write port for its whole duration, so
    // pixel writes arriving meanwhile are simply dropped.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        mem_wm = '0;
        if (state_q == S_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = {~front_q, cnt_q[AW-1:0]};
            mem_wd = color_q;
            mem_wm = '1;
        end else if (wr_go) begin
            mem_we = 1'b1;
            mem_wa = {~front_q, bus.wr_y, bus.wr_x};
            mem_wd = bus.wr_data;
            mem_wm = bus.wr_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < CH_N; k++) begin
                if (mem_wm[k]) begin
                    mem_q[mem_wa][k*CH_W +: CH_W] <= mem_wd[k*CH_W +: CH_W];
                end
            end
        end
    end

    // Reads always hit the front bank, which is never the write target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_go;
            if (rd_go) begin
                rd_data_q <= mem_q[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            color_q     <= '0;
            swap_pend_q <= 1'b0;
            front_q     <= 1'b0;
            swap_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_go) begin
                        state_q     <= S_CLEAR;
                        cnt_q       <= '0;
                        color_q     <= bus.clear_color;
                        busy_q      <= 1'b1;
                        swap_pend_q <= swap_go;
                    end else if (swap_go) begin
                        front_q     <= ~front_q;
                        swap_done_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_d;
                    if (swap_go) begin
                        swap_pend_q <= 1'b1;
                    end
                    // A swap requested on the final sweep cycle still lands here.
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        swap_pend_q <= 1'b0;
                        if (swap_pend_q || swap_go) begin
                            front_q     <= ~front_q;
                            swap_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.swap_done  = swap_done_q;
    assign bus.front_bank = front_q;
    assign bus.busy       = busy_q;
    assign state_o        = state_q;
endmodule
